// File: rtl/control_seq_n_if.sv
// Control-sequencer port bundle: datapath/memory status in, strobes out.
// The sequencer takes the master side; the datapath takes the slave side.
interface control_seq_n_if #(
    parameter int unsigned OPW = 4
);
    logic [OPW-1:0] IR;
    logic           Z;
    logic           MEM_READY;
    logic           AR_LOAD;
    logic           AR_INC;
    logic           PC_BUS;
    logic           PC_LOAD;
    logic           PC_INC;
    logic           DR_BUS_L;
    logic           DR_LOAD;
    logic           TR_BUS;
    logic           TR_LOAD;
    logic           IR_LOAD;
    logic           R_BUS;
    logic           R_LOAD;
    logic           AC_BUS;
    logic           AC_LOAD;
    logic           Z_LOAD;
    logic [3:0]     ALU_OP;
    logic           MEMBUS;
    logic           BUSMEM;
    logic           WE;
    logic           ILLEGAL;
    logic           FETCHING;

    modport master (
        input  IR, Z, MEM_READY,
        output AR_LOAD, AR_INC, PC_BUS, PC_LOAD, PC_INC, DR_BUS_L, DR_LOAD, TR_BUS,
               TR_LOAD, IR_LOAD, R_BUS, R_LOAD, AC_BUS, AC_LOAD, Z_LOAD, ALU_OP,
               MEMBUS, BUSMEM, WE, ILLEGAL, FETCHING
    );

    modport slave (
        output IR, Z, MEM_READY,
        input  AR_LOAD, AR_INC, PC_BUS, PC_LOAD, PC_INC, DR_BUS_L, DR_LOAD, TR_BUS,
               TR_LOAD, IR_LOAD, R_BUS, R_LOAD, AC_BUS, AC_LOAD, Z_LOAD, ALU_OP,
               MEMBUS, BUSMEM, WE, ILLEGAL, FETCHING
    );
endinterface

// File: rtl/control_seq_n.sv
// Hardwired fetch/decode/execute sequencer for the accumulator CPU with
// multi-byte address operands, optional memory wait states and illegal-opcode flagging.
module control_seq_n #(
    parameter int unsigned OPW        = 4,
    parameter int unsigned ADDR_BYTES = 2,
    parameter bit          WAIT_EN    = 1'b1
) (
    input logic             CLK,
    input logic             CLEAR,
    control_seq_n_if.master bus
);

    typedef enum logic [3:0] {
        StF1, StF2, StF3, StDec, StAb, StAf, StSk, StLd1, StLd2, StSt1, StSt2, StEx
    } state_e;

    localparam logic [3:0] OpNop  = 4'h0;
    localparam logic [3:0] OpLdac = 4'h1;
    localparam logic [3:0] OpStac = 4'h2;
    localparam logic [3:0] OpMvac = 4'h3;
    localparam logic [3:0] OpMovr = 4'h4;
    localparam logic [3:0] OpJump = 4'h5;
    localparam logic [3:0] OpJmpz = 4'h6;
    localparam logic [3:0] OpJpnz = 4'h7;
    localparam logic [3:0] OpAdd  = 4'h8;
    localparam logic [3:0] OpSub  = 4'h9;
    localparam logic [3:0] OpInac = 4'hA;
    localparam logic [3:0] OpClac = 4'hB;
    localparam logic [3:0] OpAnd  = 4'hC;
    localparam logic [3:0] OpOr   = 4'hD;
    localparam logic [3:0] OpXor  = 4'hE;
    localparam logic [3:0] OpNot  = 4'hF;

    localparam logic [1:0] LastK = 2'(ADDR_BYTES - 1);

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [31:0] ir_ext;
    logic [3:0]  op;
    logic        legal;
    logic        mem_go;

    assign ir_ext = 32'(bus.IR);
    assign legal  = (ir_ext < 32'd16);
    assign op     = ir_ext[3:0];
    assign mem_go = !WAIT_EN || bus.MEM_READY;

    always_ff @(posedge CLK or negedge CLEAR) begin
        if (!CLEAR) begin
            state_q <= StF1;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bus.AR_LOAD  = 1'b0;
        bus.AR_INC   = 1'b0;
        bus.PC_BUS   = 1'b0;
        bus.PC_LOAD  = 1'b0;
        bus.PC_INC   = 1'b0;
        bus.DR_BUS_L = 1'b0;
        bus.DR_LOAD  = 1'b0;
        bus.TR_BUS   = 1'b0;
        bus.TR_LOAD  = 1'b0;
        bus.IR_LOAD  = 1'b0;
        bus.R_BUS    = 1'b0;
        bus.R_LOAD   = 1'b0;
        bus.AC_BUS   = 1'b0;
        bus.AC_LOAD  = 1'b0;
        bus.Z_LOAD   = 1'b0;
        bus.ALU_OP   = 4'd0;
        bus.MEMBUS   = 1'b0;
        bus.BUSMEM   = 1'b0;
        bus.WE       = 1'b0;
        bus.ILLEGAL  = 1'b0;
        bus.FETCHING = 1'b0;

        // All strobes stay quiet while reset is held, even though the state sits in F1.
        if (CLEAR) begin
            unique case (state_q)
                StF1: begin
                    bus.PC_BUS   = 1'b1;
                    bus.AR_LOAD  = 1'b1;
                    bus.FETCHING = 1'b1;
                    state_d      = StF2;
                end
                StF2: begin
                    bus.MEMBUS = 1'b1;
                    if (mem_go) begin
                        bus.DR_LOAD = 1'b1;
                        bus.PC_INC  = 1'b1;
                        state_d     = StF3;
                    end
                end
                StF3: begin
                    bus.DR_BUS_L = 1'b1;
                    bus.IR_LOAD  = 1'b1;
                    bus.PC_BUS   = 1'b1;
                    bus.AR_LOAD  = 1'b1;
                    state_d      = StDec;
                end
                StDec: begin
                    cnt_d   = 2'd0;
                    state_d = StEx;
                    if (legal) begin
                        case (op)
                            OpLdac, OpStac, OpJump: state_d = StAb;
                            OpJmpz:                 state_d = bus.Z ? StAb : StSk;
                            OpJpnz:                 state_d = bus.Z ? StSk : StAb;
                            default:                state_d = StEx;
                        endcase
                    end
                end
                StAb: begin
                    bus.MEMBUS = 1'b1;
                    if (mem_go) begin
                        bus.DR_LOAD = 1'b1;
                        bus.PC_INC  = 1'b1;
                        bus.AR_INC  = 1'b1;
                        bus.TR_LOAD = (cnt_q != 2'd0);
                        if (cnt_q == LastK) state_d = StAf;
                        else                cnt_d   = cnt_q + 2'd1;
                    end
                end
                StAf: begin
                    bus.DR_BUS_L = 1'b1;
                    bus.TR_BUS   = (ADDR_BYTES > 1);
                    if (op == OpLdac) begin
                        bus.AR_LOAD = 1'b1;
                        state_d     = StLd1;
                    end else if (op == OpStac) begin
                        bus.AR_LOAD = 1'b1;
                        state_d     = StSt1;
                    end else begin
                        // Only taken jumps reach AF besides loads/stores.
                        bus.PC_LOAD = 1'b1;
                        state_d     = StF1;
                    end
                end
                StSk: begin
                    bus.PC_INC = 1'b1;
                    if (cnt_q == LastK) state_d = StF1;
                    else                cnt_d   = cnt_q + 2'd1;
                end
                StLd1: begin
                    bus.MEMBUS = 1'b1;
                    if (mem_go) begin
                        bus.DR_LOAD = 1'b1;
                        state_d     = StLd2;
                    end
                end
                StLd2: begin
                    bus.DR_BUS_L = 1'b1;
                    bus.AC_LOAD  = 1'b1;
                    state_d      = StF1;
                end
                StSt1: begin
                    bus.AC_BUS  = 1'b1;
                    bus.DR_LOAD = 1'b1;
                    state_d     = StSt2;
                end
                StSt2: begin
                    bus.DR_BUS_L = 1'b1;
                    bus.BUSMEM   = 1'b1;
                    if (mem_go) begin
                        bus.WE  = 1'b1;
                        state_d = StF1;
                    end
                end
                StEx: begin
                    state_d = StF1;
                    if (!legal) begin
                        bus.ILLEGAL = 1'b1;
                    end else begin
                        case (op)
                            OpMvac: begin
                                bus.AC_BUS = 1'b1;
                                bus.R_LOAD = 1'b1;
                            end
                            OpMovr: begin
                                bus.R_BUS   = 1'b1;
                                bus.AC_LOAD = 1'b1;
                            end
                            OpAdd, OpSub, OpAnd, OpOr, OpXor: begin
                                bus.R_BUS   = 1'b1;
                                bus.AC_LOAD = 1'b1;
                                bus.Z_LOAD  = 1'b1;
                                case (op)
                                    OpAdd:   bus.ALU_OP = 4'd1;
                                    OpSub:   bus.ALU_OP = 4'd2;
                                    OpAnd:   bus.ALU_OP = 4'd5;
                                    OpOr:    bus.ALU_OP = 4'd6;
                                    default: bus.ALU_OP = 4'd7;
                                endcase
                            end
                            OpInac, OpClac, OpNot: begin
                                bus.AC_LOAD = 1'b1;
                                bus.Z_LOAD  = 1'b1;
                                case (op)
                                    OpInac:  bus.ALU_OP = 4'd3;
                                    OpClac:  bus.ALU_OP = 4'd4;
                                    default: bus.ALU_OP = 4'd8;
                                endcase
                            end
                            OpNop:   ;
                            default: ;
                        endcase
                    end
                end
                default: state_d = StF1;
            endcase
        end
    end

endmodule

// File: tb/tb_control_seq_n.sv
// Directed per-cycle checks of control_seq_n in three builds:
// (OPW=4, A=2, wait), (OPW=5, A=1, no wait), (OPW=5, A=4, wait).
module tb_control_seq_n;

    localparam logic [23:0] ARL = 24'h1 << 0;
    localparam logic [23:0] ARI = 24'h1 << 1;
    localparam logic [23:0] PCB = 24'h1 << 2;
    localparam logic [23:0] PCL = 24'h1 << 3;
    localparam logic [23:0] PCI = 24'h1 << 4;
    localparam logic [23:0] DRB = 24'h1 << 5;
    localparam logic [23:0] DRL = 24'h1 << 6;
    localparam logic [23:0] TRB = 24'h1 << 7;
    localparam logic [23:0] TRL = 24'h1 << 8;
    localparam logic [23:0] IRL = 24'h1 << 9;
    localparam logic [23:0] RB  = 24'h1 << 10;
    localparam logic [23:0] RL  = 24'h1 << 11;
    localparam logic [23:0] ACB = 24'h1 << 12;
    localparam logic [23:0] ACL = 24'h1 << 13;
    localparam logic [23:0] ZL  = 24'h1 << 14;
    localparam logic [23:0] MB  = 24'h1 << 15;
    localparam logic [23:0] BM  = 24'h1 << 16;
    localparam logic [23:0] WEB = 24'h1 << 17;
    localparam logic [23:0] ILL = 24'h1 << 18;
    localparam logic [23:0] FET = 24'h1 << 19;

    localparam logic [23:0] F1W  = PCB | ARL | FET;
    localparam logic [23:0] F2W  = MB | DRL | PCI;
    localparam logic [23:0] F3W  = DRB | IRL | PCB | ARL;
    localparam logic [23:0] AB0W = MB | DRL | PCI | ARI;
    localparam logic [23:0] ABNW = AB0W | TRL;

    logic CLK = 1'b0;
    logic clear_a = 1'b0;
    logic clear_b = 1'b0;
    logic clear_c = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [23:0] exp_q [0:31];
    logic        rdy_q [0:31];
    int          exp_n = 0;

    control_seq_n_if #(.OPW(4)) bus_a ();
    control_seq_n_if #(.OPW(5)) bus_b ();
    control_seq_n_if #(.OPW(5)) bus_c ();

    control_seq_n #(.OPW(4), .ADDR_BYTES(2), .WAIT_EN(1'b1)) dut_a (
        .CLK(CLK), .CLEAR(clear_a), .bus(bus_a)
    );
    control_seq_n #(.OPW(5), .ADDR_BYTES(1), .WAIT_EN(1'b0)) dut_b (
        .CLK(CLK), .CLEAR(clear_b), .bus(bus_b)
    );
    control_seq_n #(.OPW(5), .ADDR_BYTES(4), .WAIT_EN(1'b1)) dut_c (
        .CLK(CLK), .CLEAR(clear_c), .bus(bus_c)
    );

    wire [23:0] out_a = {bus_a.ALU_OP, bus_a.FETCHING, bus_a.ILLEGAL, bus_a.WE, bus_a.BUSMEM,
        bus_a.MEMBUS, bus_a.Z_LOAD, bus_a.AC_LOAD, bus_a.AC_BUS, bus_a.R_LOAD, bus_a.R_BUS,
        bus_a.IR_LOAD, bus_a.TR_LOAD, bus_a.TR_BUS, bus_a.DR_LOAD, bus_a.DR_BUS_L,
        bus_a.PC_INC, bus_a.PC_LOAD, bus_a.PC_BUS, bus_a.AR_INC, bus_a.AR_LOAD};
    wire [23:0] out_b = {bus_b.ALU_OP, bus_b.FETCHING, bus_b.ILLEGAL, bus_b.WE, bus_b.BUSMEM,
        bus_b.MEMBUS, bus_b.Z_LOAD, bus_b.AC_LOAD, bus_b.AC_BUS, bus_b.R_LOAD, bus_b.R_BUS,
        bus_b.IR_LOAD, bus_b.TR_LOAD, bus_b.TR_BUS, bus_b.DR_LOAD, bus_b.DR_BUS_L,
        bus_b.PC_INC, bus_b.PC_LOAD, bus_b.PC_BUS, bus_b.AR_INC, bus_b.AR_LOAD};
    wire [23:0] out_c = {bus_c.ALU_OP, bus_c.FETCHING, bus_c.ILLEGAL, bus_c.WE, bus_c.BUSMEM,
        bus_c.MEMBUS, bus_c.Z_LOAD, bus_c.AC_LOAD, bus_c.AC_BUS, bus_c.R_LOAD, bus_c.R_BUS,
        bus_c.IR_LOAD, bus_c.TR_LOAD, bus_c.TR_BUS, bus_c.DR_LOAD, bus_c.DR_BUS_L,
        bus_c.PC_INC, bus_c.PC_LOAD, bus_c.PC_BUS, bus_c.AR_INC, bus_c.AR_LOAD};

    always #5 CLK = ~CLK;

    function automatic logic [23:0] alu(input int n);
        alu = 24'(n) << 20;
    endfunction

    function automatic logic [23:0] pick(input int sel);
        case (sel)
            0:       pick = out_a;
            1:       pick = out_b;
            default: pick = out_c;
        endcase
    endfunction

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %06h expected %06h", tag, got, exp);
        end
    endtask

    task automatic setin(input int sel, input logic [4:0] ir, input logic z);
        case (sel)
            0: begin bus_a.IR = ir[3:0]; bus_a.Z = z; end
            1: begin bus_b.IR = ir;      bus_b.Z = z; end
            default: begin bus_c.IR = ir; bus_c.Z = z; end
        endcase
    endtask

    task automatic set_rdy(input int sel, input logic r);
        case (sel)
            0:       bus_a.MEM_READY = r;
            1:       bus_b.MEM_READY = r;
            default: bus_c.MEM_READY = r;
        endcase
    endtask

    task automatic push(input logic [23:0] w, input logic r);
        exp_q[exp_n] = w;
        rdy_q[exp_n] = r;
        exp_n++;
    endtask

    task automatic fetch(input logic r);
        push(F1W, r);
        push(F2W, r);
        push(F3W, r);
        push(24'h0, r);
    endtask

    // Entered just after a rising edge; checks one expected word per cycle.
    task automatic play(input int sel, input string name);
        for (int i = 0; i < exp_n; i++) begin
            set_rdy(sel, rdy_q[i]);
            @(negedge CLK);
            check($sformatf("%s_c%0d", name, i), pick(sel), exp_q[i]);
            @(posedge CLK);
            #1;
        end
        exp_n = 0;
    endtask

    initial begin
        setin(0, 5'h0, 1'b0);
        setin(1, 5'h0, 1'b0);
        setin(2, 5'h0, 1'b0);
        set_rdy(0, 1'b1);
        set_rdy(1, 1'b1);
        set_rdy(2, 1'b1);

        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check($sformatf("rst_a%0d", i), out_a, 24'h0);
        end
        check("rst_b", out_b, 24'h0);
        check("rst_c", out_c, 24'h0);
        @(posedge CLK);
        #1;
        clear_a = 1'b1;

        setin(0, 5'h0, 1'b0);
        fetch(1'b1); push(24'h0, 1'b1);
        play(0, "nop");

        setin(0, 5'h1, 1'b0);
        fetch(1'b1); push(AB0W, 1'b1); push(ABNW, 1'b1); push(DRB | TRB | ARL, 1'b1);
        push(MB | DRL, 1'b1); push(DRB | ACL, 1'b1);
        play(0, "ldac");

        setin(0, 5'h2, 1'b0);
        fetch(1'b1); push(AB0W, 1'b1); push(ABNW, 1'b1); push(DRB | TRB | ARL, 1'b1);
        push(ACB | DRL, 1'b1);
        for (int i = 0; i < 3; i++) push(DRB | BM, 1'b0);
        push(DRB | BM | WEB, 1'b1);
        play(0, "stac_wait");

        setin(0, 5'h6, 1'b1);
        fetch(1'b1); push(AB0W, 1'b1); push(ABNW, 1'b1); push(DRB | TRB | PCL, 1'b1);
        play(0, "jmpz_t");

        setin(0, 5'h6, 1'b0);
        fetch(1'b1); push(PCI, 1'b1); push(PCI, 1'b1);
        play(0, "jmpz_n");

        setin(0, 5'h7, 1'b0);
        fetch(1'b1); push(MB, 1'b0); push(AB0W, 1'b1); push(ABNW, 1'b1);
        push(DRB | TRB | PCL, 1'b1);
        play(0, "jpnz_wait");

        setin(0, 5'h8, 1'b0);
        push(F1W, 1'b1); push(MB, 1'b0); push(F2W, 1'b1); push(F3W, 1'b1); push(24'h0, 1'b1);
        push(RB | ACL | ZL | alu(1), 1'b1);
        play(0, "add_f2wait");

        setin(0, 5'hF, 1'b0);
        fetch(1'b1); push(ACL | ZL | alu(8), 1'b1);
        play(0, "not");

        setin(0, 5'h4, 1'b0);
        fetch(1'b1); push(RB | ACL, 1'b1);
        play(0, "movr");

        setin(0, 5'h3, 1'b0);
        fetch(1'b1); push(ACB | RL, 1'b1);
        play(0, "mvac");

        push(F1W, 1'b1);
        play(0, "a_end");

        // Build b ignores MEM_READY, so it is held low throughout.
        clear_b = 1'b1;
        setin(1, 5'h13, 1'b0);
        fetch(1'b0); push(ILL, 1'b0);
        play(1, "illegal");

        setin(1, 5'h1, 1'b0);
        fetch(1'b0); push(AB0W, 1'b0); push(DRB | ARL, 1'b0); push(MB | DRL, 1'b0);
        push(DRB | ACL, 1'b0);
        play(1, "ldac_a1");

        push(F1W, 1'b0);
        play(1, "b_end");

        clear_c = 1'b1;
        setin(2, 5'h5, 1'b0);
        fetch(1'b1); push(AB0W, 1'b1);
        for (int i = 0; i < 3; i++) push(ABNW, 1'b1);
        push(DRB | TRB | PCL, 1'b1);
        play(2, "jump_a4");

        setin(2, 5'h2, 1'b0);
        fetch(1'b1); push(AB0W, 1'b1); push(ABNW, 1'b1);
        play(2, "stac_pre");
        clear_c = 1'b0;
        set_rdy(2, 1'b0);
        @(negedge CLK);
        check("abort_rst", out_c, 24'h0);
        @(posedge CLK);
        #1;
        clear_c = 1'b1;
        setin(2, 5'h0, 1'b0);
        fetch(1'b1); push(24'h0, 1'b1); push(F1W, 1'b1);
        play(2, "after_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_seq_n.md
# control_seq_n

Parametrised hardwired sequencer for the accumulator CPU. It generates per-cycle register load, bus-drive, ALU-select and memory strobes for fetch, decode and execute. Over the earlier fixed control unit it adds three things: a configurable operand-address length (ADDR_BYTES memory bytes per address), an optional memory wait-state handshake (MEM_READY), and detection of out-of-range opcodes. It sits between the datapath register file/ALU and the memory port, and owns no data.

## Interface
- OPW, 4: IR opcode width (≥4); opcodes ≥16 are illegal.
- ADDR_BYTES, 2: address operand bytes per LDAC/STAC/JUMP/JMPZ/JPNZ (1..4).
- WAIT_EN, 1: 1 = memory states stall on MEM_READY; 0 = MEM_READY ignored, every access one cycle.
- CLK  in  1  clock, all state changes on rising edge.
- CLEAR  in  1  asynchronous, active-low reset.
- IR  in  OPW  current instruction register contents.
- Z  in  1  datapath zero flag.
- MEM_READY  in  1  memory completes access this cycle.
- AR_LOAD, AR_INC, PC_BUS, PC_LOAD, PC_INC, DR_BUS_L, DR_LOAD, TR_BUS, TR_LOAD, IR_LOAD, R_BUS, R_LOAD, AC_BUS, AC_LOAD, Z_LOAD  out  1 each  datapath strobes.
  - TR_LOAD shifts DR into the TR low byte.
- ALU_OP  out  4  0 PASS, 1 ADD, 2 SUB, 3 INC, 4 CLR, 5 AND, 6 OR, 7 XOR, 8 NOT.
- MEMBUS, BUSMEM, WE  out  1 each  memory-to-bus read enable, bus-to-memory drive, write strobe.
- ILLEGAL  out  1  one-cycle pulse on illegal opcode.
- FETCHING  out  1  high in state F1, instruction boundary marker.

## Operation
- Opcode map: 0 NOP, 1 LDAC, 2 STAC, 3 MVAC, 4 MOVR, 5 JUMP, 6 JMPZ, 7 JPNZ, 8 ADD, 9 SUB, A INAC, B CLAC, C AND, D OR, E XOR, F NOT.
- States and asserted outputs (unlisted strobes are 0; ALU_OP is 0 unless stated):
  - F1: PC_BUS, AR_LOAD.
  - F2 (mem): MEMBUS, DR_LOAD, PC_INC.
  - F3: DR_BUS_L, IR_LOAD, PC_BUS, AR_LOAD.
  - DEC: no outputs; next state from IR.
  - AB[k], k = 0..ADDR_BYTES-1 (mem): MEMBUS, DR_LOAD, PC_INC, AR_INC; TR_LOAD also when k ≥ 1.
  - AF: DR_BUS_L, TR_BUS (only if ADDR_BYTES > 1), plus AR_LOAD for LDAC/STAC or PC_LOAD for taken jumps.
  - SK[k], k = 0..ADDR_BYTES-1: PC_INC (not-taken JMPZ/JPNZ).
  - LD1 (mem): MEMBUS, DR_LOAD. LD2: DR_BUS_L, AC_LOAD, ALU_OP = PASS.
  - ST1: AC_BUS, DR_LOAD. ST2 (mem): DR_BUS_L, BUSMEM, WE.
  - EX, single cycle:
    - MVAC: AC_BUS, R_LOAD.
    - MOVR: R_BUS, AC_LOAD, PASS.
    - ADD/SUB/AND/OR/XOR: R_BUS, AC_LOAD, Z_LOAD, matching ALU_OP.
    - INAC/CLAC/NOT: AC_LOAD, Z_LOAD, matching ALU_OP.
    - NOP and illegal: none.
- Transitions:
  - F1→F2→F3→DEC.
  - DEC→EX for single-cycle opcodes.
  - DEC→AB[0] for LDAC, STAC, JUMP, JMPZ with Z=1, JPNZ with Z=0.
  - DEC→SK[0] for not-taken JMPZ/JPNZ.
  - AB[last]→AF. AF→LD1, ST1, or F1 (jumps).
  - LD2, ST2, SK[last], EX→F1.
- Z is sampled only in DEC.
- Illegal opcode: ILLEGAL=1 in its EX cycle, otherwise treated as NOP.

## Timing
- Reset: all outputs 0 while CLEAR=0, state forced to F1 asynchronously. First F1 is in the first cycle after CLEAR rises.
- Memory states are F2, AB[k], LD1 and ST2. With WAIT_EN=1 and MEM_READY=0:
  - the state holds;
  - MEMBUS/BUSMEM stay asserted;
  - DR_LOAD, WE, PC_INC, AR_INC and TR_LOAD are forced to 0.
  - All strobes fire only in the cycle MEM_READY=1, then the state advances.
- Zero-wait latency with ADDR_BYTES=A (clocks per instruction):
  - single-cycle ops: 5;
  - LDAC/STAC: 7+A;
  - taken jump: 5+A;
  - not-taken jump: 4+A.
- Asserting CLEAR during a wait or mid-instruction aborts the instruction. No partial WE pulse may follow.

## Test plan
- Reset/fetch: hold CLEAR=0 for 3 clocks, release, MEM_READY=1, IR=0 → all outputs 0 during reset; FETCHING=1 in cycle 1; F1..EX spans 5 cycles; next FETCHING=1 in cycle 6.
- LDAC with ADDR_BYTES=2:
  - AB0 asserts DR_LOAD and PC_INC, with TR_LOAD=0.
  - AB1 asserts TR_LOAD.
  - AF asserts AR_LOAD, TR_BUS and DR_BUS_L.
  - LD2 asserts AC_LOAD with ALU_OP=0.
  - Total is 9 cycles.
- Wait states: STAC with MEM_READY low for 3 cycles in ST2 → BUSMEM held 4 cycles; WE=1 only in the 4th; total 12 cycles.
- Branches: JMPZ with Z=1 → AF asserts PC_LOAD, 7 cycles total; Z=0 → two SK cycles with PC_INC, no PC_LOAD, 6 cycles total.
- ALU ops: ADD → R_BUS, AC_LOAD, Z_LOAD with ALU_OP=1; NOT → ALU_OP=8 with R_BUS=0; MOVR → Z_LOAD=0.
- OPW=5 and ADDR_BYTES=1/4 builds:
  - IR=0x13 → ILLEGAL pulses exactly 1 cycle, no strobes.
  - ADDR_BYTES=1: LDAC is 8 cycles with TR_BUS never asserted.
  - ADDR_BYTES=4: JUMP taken is 9 cycles.
  - CLEAR pulsed mid-AB[2] → F1 next with no WE.
